// File: rtl/qr3_inv_seq.sv
// Inverse ChaCha quarter round, one step per clock, ITERS rounds per accepted input, valid/ready on both sides.
// Define QR3_INV_CHECK_EN to re-run the forward round on the result and flag mismatches on chk_err.
module qr3_inv_seq #(
    parameter int ITERS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    input  logic [31:0] c_in,
    input  logic [31:0] d_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] a_out,
    output logic [31:0] b_out,
    output logic [31:0] c_out,
    output logic [31:0] d_out,
    output logic        busy
`ifdef QR3_INV_CHECK_EN
    ,
    output logic        chk_err
`endif
);

`ifdef QR3_INV_CHECK_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DONE  = 2'd2,
        S_CHECK = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;
`endif

    localparam logic [5:0] ITER_LAST = 6'(ITERS - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_step;
    logic [5:0]  r_iter;
    logic [31:0] r_a, r_b, r_c, r_d;
    logic [31:0] w_inv_a, w_inv_b, w_inv_c, w_inv_d;
    logic        w_accept;
    logic        w_last_step;
    logic        w_last_iter;

    assign w_accept    = (r_state == S_IDLE) && in_valid;
    assign w_last_step = (r_step == 2'd3);
    assign w_last_iter = (r_iter == ITER_LAST);

    // Inverse steps undo the forward steps in reverse; a/d steps read the pre-edge a.
    always_comb begin
        w_inv_a = r_a;
        w_inv_b = r_b;
        w_inv_c = r_c;
        w_inv_d = r_d;
        case (r_step)
            2'd0: begin
                w_inv_b = {r_b[6:0], r_b[31:7]} ^ r_c;
                w_inv_c = r_c - r_d;
            end
            2'd1: begin
                w_inv_a = r_a - r_b;
                w_inv_d = {r_d[7:0], r_d[31:8]} ^ r_a;
            end
            2'd2: begin
                w_inv_b = {r_b[11:0], r_b[31:12]} ^ r_c;
                w_inv_c = r_c - r_d;
            end
            default: begin
                w_inv_a = r_a - r_b;
                w_inv_d = {r_d[15:0], r_d[31:16]} ^ r_a;
            end
        endcase
    end

`ifdef QR3_INV_CHECK_EN
    logic [31:0] r_cpy_a, r_cpy_b, r_cpy_c, r_cpy_d;
    logic [31:0] r_k_a, r_k_b, r_k_c, r_k_d;
    logic [31:0] w_fwd_a, w_fwd_b, w_fwd_c, w_fwd_d;
    logic [31:0] w_sum;
    logic        r_chk_err;

    always_comb begin
        w_fwd_a = r_k_a;
        w_fwd_b = r_k_b;
        w_fwd_c = r_k_c;
        w_fwd_d = r_k_d;
        w_sum   = 32'd0;
        case (r_step)
            2'd0: begin
                w_sum   = r_k_a + r_k_b;
                w_fwd_a = w_sum;
                w_fwd_d = {w_sum[15:0] ^ r_k_d[15:0], w_sum[31:16] ^ r_k_d[31:16]};
            end
            2'd1: begin
                w_sum   = r_k_c + r_k_d;
                w_fwd_c = w_sum;
                w_fwd_b = {w_sum[19:0] ^ r_k_b[19:0], w_sum[31:20] ^ r_k_b[31:20]};
            end
            2'd2: begin
                w_sum   = r_k_a + r_k_b;
                w_fwd_a = w_sum;
                w_fwd_d = {w_sum[23:0] ^ r_k_d[23:0], w_sum[31:24] ^ r_k_d[31:24]};
            end
            default: begin
                w_sum   = r_k_c + r_k_d;
                w_fwd_c = w_sum;
                w_fwd_b = {w_sum[24:0] ^ r_k_b[24:0], w_sum[31:25] ^ r_k_b[31:25]};
            end
        endcase
    end

    assign chk_err = r_chk_err;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_last_step && w_last_iter) begin
`ifdef QR3_INV_CHECK_EN
                    w_state_nxt = S_CHECK;
`else
                    w_state_nxt = S_DONE;
`endif
                end
            end
`ifdef QR3_INV_CHECK_EN
            S_CHECK: begin
                if (w_last_step && w_last_iter) w_state_nxt = S_DONE;
            end
`endif
            S_DONE: begin
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step <= 2'd0;
            r_iter <= 6'd0;
            r_a    <= 32'd0;
            r_b    <= 32'd0;
            r_c    <= 32'd0;
            r_d    <= 32'd0;
`ifdef QR3_INV_CHECK_EN
            r_cpy_a   <= 32'd0;
            r_cpy_b   <= 32'd0;
            r_cpy_c   <= 32'd0;
            r_cpy_d   <= 32'd0;
            r_k_a     <= 32'd0;
            r_k_b     <= 32'd0;
            r_k_c     <= 32'd0;
            r_k_d     <= 32'd0;
            r_chk_err <= 1'b0;
`endif
        end else if (w_accept) begin
            r_step <= 2'd0;
            r_iter <= 6'd0;
            r_a    <= a_in;
            r_b    <= b_in;
            r_c    <= c_in;
            r_d    <= d_in;
`ifdef QR3_INV_CHECK_EN
            r_cpy_a   <= a_in;
            r_cpy_b   <= b_in;
            r_cpy_c   <= c_in;
            r_cpy_d   <= d_in;
            r_chk_err <= 1'b0;
`endif
        end else if (r_state == S_RUN) begin
            r_a    <= w_inv_a;
            r_b    <= w_inv_b;
            r_c    <= w_inv_c;
            r_d    <= w_inv_d;
            r_step <= r_step + 2'd1;
            // Iteration counter wraps to 0 at the end so CHECK can reuse it.
            if (w_last_step) r_iter <= w_last_iter ? 6'd0 : r_iter + 6'd1;
`ifdef QR3_INV_CHECK_EN
            if (w_last_step && w_last_iter) begin
                r_k_a <= w_inv_a;
                r_k_b <= w_inv_b;
                r_k_c <= w_inv_c;
                r_k_d <= w_inv_d;
            end
`endif
        end
`ifdef QR3_INV_CHECK_EN
        else if (r_state == S_CHECK) begin
            r_k_a  <= w_fwd_a;
            r_k_b  <= w_fwd_b;
            r_k_c  <= w_fwd_c;
            r_k_d  <= w_fwd_d;
            r_step <= r_step + 2'd1;
            if (w_last_step) r_iter <= w_last_iter ? 6'd0 : r_iter + 6'd1;
            if (w_last_step && w_last_iter) begin
                r_chk_err <= (w_fwd_a != r_cpy_a) || (w_fwd_b != r_cpy_b) ||
                             (w_fwd_c != r_cpy_c) || (w_fwd_d != r_cpy_d);
            end
        end
`endif
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
`ifdef QR3_INV_CHECK_EN
    assign busy      = (r_state == S_RUN) || (r_state == S_CHECK);
`else
    assign busy      = (r_state == S_RUN);
`endif
    assign a_out = r_a;
    assign b_out = r_b;
    assign c_out = r_c;
    assign d_out = r_d;

endmodule

// File: tb/tb_qr3_inv_seq.sv
// Bench for qr3_inv_seq: ITERS=1 known vector and ITERS=3 randomized round trips against a forward-round model.
module tb_qr3_inv_seq;

    localparam int IT3 = 3;
`ifdef QR3_INV_CHECK_EN
    localparam int MUL = 2;
`else
    localparam int MUL = 1;
`endif
    localparam int LAT1 = 4 * MUL;
    localparam int LAT3 = 4 * IT3 * MUL;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        in_valid, in_ready, out_valid, out_ready, busy, chk_err;
    logic [31:0] a_in, b_in, c_in, d_in, a_out, b_out, c_out, d_out;
    logic        k_in_valid, k_in_ready, k_out_valid, k_out_ready, k_busy, k_chk_err;
    logic [31:0] k_a_in, k_b_in, k_c_in, k_d_in, k_a_out, k_b_out, k_c_out, k_d_out;

    qr3_inv_seq #(.ITERS(IT3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .a_out(a_out), .b_out(b_out), .c_out(c_out), .d_out(d_out),
        .busy(busy)
`ifdef QR3_INV_CHECK_EN
        , .chk_err(chk_err)
`endif
    );

    qr3_inv_seq #(.ITERS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(k_in_valid), .in_ready(k_in_ready),
        .a_in(k_a_in), .b_in(k_b_in), .c_in(k_c_in), .d_in(k_d_in),
        .out_valid(k_out_valid), .out_ready(k_out_ready),
        .a_out(k_a_out), .b_out(k_b_out), .c_out(k_c_out), .d_out(k_d_out),
        .busy(k_busy)
`ifdef QR3_INV_CHECK_EN
        , .chk_err(k_chk_err)
`endif
    );

`ifndef QR3_INV_CHECK_EN
    assign chk_err   = 1'b0;
    assign k_chk_err = 1'b0;
`endif

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    task automatic fwd_qr(inout logic [31:0] a, inout logic [31:0] b,
                          inout logic [31:0] c, inout logic [31:0] d);
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
    endtask

    // Drives one input into dut3 (assumed idle, out_ready high) and returns the result and latency.
    task automatic run3(input logic [31:0] ia, ib, ic, id,
                        output logic [31:0] oa, ob, oc, od, output int lat);
        @(negedge clk);
        in_valid = 1'b1; a_in = ia; b_in = ib; c_in = ic; d_in = id;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1;
        for (int n = 1; n <= LAT3 + 20; n++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        oa = a_out; ob = b_out; oc = c_out; od = d_out;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; a_in = '0; b_in = '0; c_in = '0; d_in = '0;
        k_in_valid = 1'b0; k_out_ready = 1'b1; k_a_in = '0; k_b_in = '0; k_c_in = '0; k_d_in = '0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({in_ready, out_valid, busy, chk_err} !== 4'b1000) begin
            fails++;
            $display("FAIL reset_ctrl: got rdy/vld/busy/err=%b expected 1000", {in_ready, out_valid, busy, chk_err});
        end
        tests++;
        if ({a_out, b_out, c_out, d_out} !== 128'd0) begin
            fails++;
            $display("FAIL reset_data: got %h expected 0", {a_out, b_out, c_out, d_out});
        end
        tests++;
        if ({k_in_ready, k_out_valid, k_busy, k_chk_err} !== 4'b1000 || {k_a_out, k_b_out, k_c_out, k_d_out} !== 128'd0) begin
            fails++;
            $display("FAIL reset_dut1: got ctrl=%b data=%h", {k_in_ready, k_out_valid, k_busy, k_chk_err},
                     {k_a_out, k_b_out, k_c_out, k_d_out});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_known_vector;
        int lat;
        @(negedge clk);
        k_in_valid = 1'b1;
        k_a_in = 32'hea2a92f4; k_b_in = 32'hcb1cf8ce; k_c_in = 32'h4581472e; k_d_in = 32'h5881c4bb;
        @(posedge clk); #1;
        k_in_valid = 1'b0;
        lat = -1;
        for (int n = 1; n <= LAT1 + 20; n++) begin
            @(posedge clk); #1;
            if (k_out_valid) begin
                lat = n;
                break;
            end
        end
        tests++;
        if (lat !== LAT1) begin
            fails++;
            $display("FAIL known_latency: got %0d expected %0d", lat, LAT1);
        end
        tests++;
        if ({k_a_out, k_b_out, k_c_out, k_d_out} !== {32'h11111111, 32'h01020304, 32'h9b8d6f43, 32'h01234567}) begin
            fails++;
            $display("FAIL known_data: got %h %h %h %h expected 11111111 01020304 9b8d6f43 01234567",
                     k_a_out, k_b_out, k_c_out, k_d_out);
        end
        tests++;
        if (k_chk_err !== 1'b0) begin
            fails++;
            $display("FAIL known_chk_err: got %b expected 0", k_chk_err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_round_trip;
        logic [31:0] oa, ob, oc, od, fa, fb, fc, fd, ra, rb, rc, rd;
        int lat;
        for (int v = 0; v < 1000; v++) begin
            oa = $urandom; ob = $urandom; oc = $urandom; od = $urandom;
            fa = oa; fb = ob; fc = oc; fd = od;
            for (int r = 0; r < IT3; r++) fwd_qr(fa, fb, fc, fd);
            run3(fa, fb, fc, fd, ra, rb, rc, rd, lat);
            tests++;
            if ({ra, rb, rc, rd} !== {oa, ob, oc, od} || lat !== LAT3 || chk_err !== 1'b0) begin
                fails++;
                $display("FAIL round_trip[%0d]: got %h lat %0d err %b expected %h lat %0d err 0",
                         v, {ra, rb, rc, rd}, lat, chk_err, {oa, ob, oc, od}, LAT3);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] oa, ob, oc, od, fa, fb, fc, fd;
        logic [127:0] snap;
        bit seen;
        oa = $urandom; ob = $urandom; oc = $urandom; od = $urandom;
        fa = oa; fb = ob; fc = oc; fd = od;
        for (int r = 0; r < IT3; r++) fwd_qr(fa, fb, fc, fd);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; a_in = fa; b_in = fb; c_in = fc; d_in = fd;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 1'b0;
        for (int n = 1; n <= LAT3 + 20; n++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        snap = {a_out, b_out, c_out, d_out};
        tests++;
        if (!seen || snap !== {oa, ob, oc, od}) begin
            fails++;
            $display("FAIL bp_result: seen %b got %h expected %h", seen, snap, {oa, ob, oc, od});
        end
        // Offer a new input while stalled; it must not be taken.
        in_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {a_out, b_out, c_out, d_out} !== snap) begin
                fails++;
                $display("FAIL bp_hold[%0d]: vld %b rdy %b data %h expected 1 0 %h", n, out_valid, in_ready,
                         {a_out, b_out, c_out, d_out}, snap);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: vld %b rdy %b expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_input_during_run;
        logic [31:0] oa, ob, oc, od, fa, fb, fc, fd;
        int lat;
        bit bad;
        oa = $urandom; ob = $urandom; oc = $urandom; od = $urandom;
        fa = oa; fb = ob; fc = oc; fd = od;
        for (int r = 0; r < IT3; r++) fwd_qr(fa, fb, fc, fd);
        @(negedge clk);
        in_valid = 1'b1; a_in = fa; b_in = fb; c_in = fc; d_in = fd;
        @(posedge clk); #1;
        a_in = $urandom; b_in = $urandom; c_in = $urandom; d_in = $urandom;
        bad = 1'b0;
        lat = -1;
        for (int n = 1; n <= LAT3 + 20; n++) begin
            if (n == LAT3 - 1) in_valid = 1'b0;
            @(posedge clk); #1;
            if (n < LAT3 && (busy !== 1'b1 || in_ready !== 1'b0)) bad = 1'b1;
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        in_valid = 1'b0;
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL run_busy: busy/in_ready not 1/0 during run");
        end
        tests++;
        if ({a_out, b_out, c_out, d_out} !== {oa, ob, oc, od} || lat !== LAT3) begin
            fails++;
            $display("FAIL run_ignore: got %h lat %0d expected %h lat %0d", {a_out, b_out, c_out, d_out}, lat,
                     {oa, ob, oc, od}, LAT3);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run;
        logic [31:0] oa, ob, oc, od, fa, fb, fc, fd, ra, rb, rc, rd;
        int lat;
        fa = $urandom; fb = $urandom; fc = $urandom; fd = $urandom;
        @(negedge clk);
        in_valid = 1'b1; a_in = fa; b_in = fb; c_in = fc; d_in = fd;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({in_ready, out_valid, busy, chk_err} !== 4'b1000 || {a_out, b_out, c_out, d_out} !== 128'd0) begin
            fails++;
            $display("FAIL mid_reset: ctrl %b data %h expected 1000 and 0", {in_ready, out_valid, busy, chk_err},
                     {a_out, b_out, c_out, d_out});
        end
        @(negedge clk);
        rst_n = 1'b1;
        oa = $urandom; ob = $urandom; oc = $urandom; od = $urandom;
        fa = oa; fb = ob; fc = oc; fd = od;
        for (int r = 0; r < IT3; r++) fwd_qr(fa, fb, fc, fd);
        run3(fa, fb, fc, fd, ra, rb, rc, rd, lat);
        tests++;
        if ({ra, rb, rc, rd} !== {oa, ob, oc, od} || lat !== LAT3) begin
            fails++;
            $display("FAIL after_reset: got %h lat %0d expected %h lat %0d", {ra, rb, rc, rd}, lat,
                     {oa, ob, oc, od}, LAT3);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] oa, ob, oc, od, fa, fb, fc, fd;
        int acc_t[3];
        int na, nres;
        oa = $urandom; ob = $urandom; oc = $urandom; od = $urandom;
        fa = oa; fb = ob; fc = oc; fd = od;
        for (int r = 0; r < IT3; r++) fwd_qr(fa, fb, fc, fd);
        na = 0; nres = 0;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1; a_in = fa; b_in = fb; c_in = fc; d_in = fd;
        for (int n = 0; n < 4 * (LAT3 + 2); n++) begin
            if (in_valid && in_ready && na < 3) begin
                acc_t[na] = cyc;
                na++;
            end else if (na == 3 && !in_ready) begin
                in_valid = 1'b0;
            end
            if (out_valid) begin
                nres++;
                tests++;
                if ({a_out, b_out, c_out, d_out} !== {oa, ob, oc, od}) begin
                    fails++;
                    $display("FAIL b2b_data[%0d]: got %h expected %h", nres, {a_out, b_out, c_out, d_out},
                             {oa, ob, oc, od});
                end
            end
            if (nres == 3) break;
            @(negedge clk);
        end
        in_valid = 1'b0;
        tests++;
        if (na !== 3 || nres !== 3) begin
            fails++;
            $display("FAIL b2b_count: accepts %0d results %0d expected 3 3", na, nres);
        end else begin
            for (int i = 1; i < 3; i++) begin
                tests++;
                if (acc_t[i] - acc_t[i-1] !== LAT3 + 2) begin
                    fails++;
                    $display("FAIL b2b_interval[%0d]: got %0d expected %0d", i, acc_t[i] - acc_t[i-1], LAT3 + 2);
                end
            end
        end
        @(posedge clk); #1;
    endtask

`ifdef QR3_INV_CHECK_EN
    task automatic test_chk_err;
        logic [31:0] oa, ob, oc, od, fa, fb, fc, fd;
        bit seen;
        oa = $urandom; ob = $urandom; oc = $urandom; od = $urandom;
        fa = oa; fb = ob; fc = oc; fd = od;
        for (int r = 0; r < IT3; r++) fwd_qr(fa, fb, fc, fd);
        @(negedge clk);
        in_valid = 1'b1; a_in = fa; b_in = fb; c_in = fc; d_in = fd;
        @(posedge clk); #1;
        in_valid = 1'b0;
        force dut3.r_cpy_a = fa ^ 32'd1;
        seen = 1'b0;
        for (int n = 1; n <= LAT3 + 20; n++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        release dut3.r_cpy_a;
        tests++;
        if (!seen || chk_err !== 1'b1) begin
            fails++;
            $display("FAIL chk_err_set: seen %b chk_err %b expected 1", seen, chk_err);
        end
        @(posedge clk); #1;
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        tests++;
        if (chk_err !== 1'b0) begin
            fails++;
            $display("FAIL chk_err_clear: got %b expected 0", chk_err);
        end
        for (int n = 1; n <= LAT3 + 20; n++) begin
            @(posedge clk); #1;
            if (out_valid) break;
        end
        tests++;
        if (chk_err !== 1'b0 || {a_out, b_out, c_out, d_out} !== {oa, ob, oc, od}) begin
            fails++;
            $display("FAIL chk_err_rerun: err %b data %h expected 0 %h", chk_err, {a_out, b_out, c_out, d_out},
                     {oa, ob, oc, od});
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_known_vector();
        test_round_trip();
        test_backpressure();
        test_input_during_run();
        test_reset_mid_run();
        test_back_to_back();
`ifdef QR3_INV_CHECK_EN
        test_chk_err();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/qr3_inv_seq.md
# qr3_inv_seq

Sequential inverse ChaCha quarter-round engine: takes the four 32-bit words produced by the forward quarter round and recovers the original words, undoing one step per clock. It sits on the verification/decode side of the RNG core, alongside the combinational forward quarter round, and uses a valid/ready handshake on both ends. Parameter `ITERS` undoes that many forward rounds applied back-to-back to the same four words.

## Interface
- `ITERS`, default 1, number of inverse quarter rounds to apply; legal range 1..64.
- `clk`  input  1  clock, all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  input words are valid.
- `in_ready`  output  1  engine can accept input.
- `a_in`, `b_in`, `c_in`, `d_in`  input  32 each  words produced by the forward quarter round.
- `out_valid`  output  1  recovered words are valid.
- `out_ready`  input  1  downstream accepts the result.
- `a_out`, `b_out`, `c_out`, `d_out`  output  32 each  recovered original words.
- `busy`  output  1  high in RUN or CHECK.
- `chk_err`  output  1  self-check mismatch. This port exists only when `QR3_INV_CHECK_EN` is defined.

## Operation
- States: IDLE, RUN, CHECK (only with the macro), DONE.
- IDLE: `in_ready` is 1. When `in_valid` and `in_ready` are both high, the engine latches `a_in`..`d_in` into working registers and into a copy register (copy register only with the macro). It then clears the step counter (2 bits) and the iteration counter (6 bits) and enters RUN.
- RUN: one inverse step per cycle, in the order step counter 0→3. Addition and subtraction are modulo 2^32; `rotr` is a 32-bit rotate right.
  - Step 0: `b = rotr(b,7) ^ c`; `c = c - d`.
  - Step 1: `a = a - b`; `d = rotr(d,8) ^ a_old`.
  - Step 2: `b = rotr(b,12) ^ c`; `c = c - d`.
  - Step 3: `a = a - b`; `d = rotr(d,16) ^ a_old`.
  - Within step 1 and step 3, the right-hand sides use the register values from before the clock edge.
  - After step 3: if the iteration counter equals `ITERS-1`, go to DONE (or to CHECK with the macro). Otherwise increment the iteration counter and restart at step 0.
- DONE: `out_valid` is 1 and the `*_out` outputs show the working registers, held stable until `out_valid` and `out_ready` are both high. On that handshake, go to IDLE.
- `in_ready` is 0 in RUN, CHECK and DONE; input offered then is ignored and not queued.
- Outputs are registered; `*_out` mirror the working registers at all times but are meaningful only while `out_valid` is 1.
- Reset, at any time including mid-run: state goes to IDLE, all counters and data registers go to 0, and the in-flight operation is discarded.
  - Reset values: `in_ready`=1, `out_valid`=0, `busy`=0, `*_out`=0, `chk_err`=0.

## Timing
- Input accepted at edge k → `out_valid` is high after edge k+4·ITERS (plus 4·ITERS more cycles with the macro).
- Back-to-back throughput: one result per 4·ITERS+2 cycles when `out_ready` is held high. That is one accept cycle, 4·ITERS RUN cycles and one DONE cycle.
- `out_ready` high in the first DONE cycle retires the result at that edge; `in_ready` rises in the following cycle.
- `out_ready` held low stalls in DONE indefinitely with outputs constant.

## Configuration
- `QR3_INV_CHECK_EN` defined:
  - Adds the CHECK state and the `chk_err` port.
  - In CHECK, a second register set, loaded with the recovered words, runs the forward quarter round for ITERS rounds, one step per cycle in forward order. The forward steps are: `a+=b, d=rotl(d^a,16)`; `c+=d, b=rotl(b^c,12)`; `a+=b, d=rotl(d^a,8)`; `c+=d, b=rotl(b^c,7)`.
  - After CHECK, the result is compared with the copy register. `chk_err` is set to 1 on any mismatch and is valid while `out_valid` is high.
  - `chk_err` is cleared on the next accepted input.
- `QR3_INV_CHECK_EN` undefined: no CHECK state, no copy or check registers, no `chk_err` port; RUN goes directly to DONE.

## Test plan
- Known vector, ITERS=1: input a=ea2a92f4, b=cb1cf8ce, c=4581472e, d=5881c4bb → after 4 cycles out a=11111111, b=01020304, c=9b8d6f43, d=01234567. With the macro, `chk_err`=0 and the result arrives after 8 cycles.
- Round trip, ITERS=3: the bench applies the forward round 3 times to random words and feeds the result in → the original words appear after 12 cycles; this holds for 1000 random vectors.
- Backpressure: `out_ready` held low for 20 cycles in DONE → `*_out` and `out_valid` stay constant and `in_ready` stays 0; raising `out_ready` retires the result, and `in_ready`=1 in the next cycle.
- Input during RUN: `in_valid` pulsed while `busy`=1 with different words → ignored, and the result matches only the first input.
- Reset mid-run: `rst_n` asserted at step 2 of iteration 0 → all outputs return to reset values at once; a fresh input after reset gives a correct result.
- With the macro, corrupt the copy register via force, flipping bit 0 of a → `chk_err`=1 with `out_valid`; the next accepted input clears it to 0.
